survivor_selector_n: RTL and testbench
======================================

Name: survivor_selector_n

Overview:
Parametrised successor to the 4-state survivor selector in the Viterbi decoder. It sits between the add-compare-select/path-update stage and the traceback/output buffer.
- Takes NUM_STATES survivor paths and their accumulated metrics.
- Picks the minimum-metric state through a registered compare tree.
- Emits the winning path, its index, its metric and a renormalisation request, with the write pointer carried alongside.
- Adds a terminated-trellis mode and pipeline flush on refresh.

Parameters:
- NUM_STATES, 4, number of trellis states; a power of 2, >= 2.
- PATH_W, 8, survivor path width in bits.
- METRIC_W, 4, accumulated metric width in bits (unsigned).
- PTR_W, 3, write pointer width.
- NORM_THRESH, 8, renormalisation threshold; norm_req is raised when the selected metric is >= this value.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-low: clears all state on a clk edge while rst=0.
- refresh  input  1  synchronous pipeline flush.
- valid_in  input  1  input vector valid.
- term_mode  input  1  1 = force selection of state 0 (terminated trellis).
- paths_in  input  NUM_STATES*PATH_W  state i path at [i*PATH_W +: PATH_W].
- metrics_in  input  NUM_STATES*METRIC_W  state i metric at [i*METRIC_W +: METRIC_W].
- write_pointer_in  input  PTR_W  buffer pointer travelling with the vector.
- selected_path  output  PATH_W  winning survivor path.
- best_state  output  log2(NUM_STATES)  winning state index.
- min_metric  output  METRIC_W  winning metric.
- write_pointer_out  output  PTR_W  write_pointer_in of the same vector.
- norm_req  output  1  winning metric >= NORM_THRESH.
- valid_out  output  1  outputs valid this cycle.

Behaviour:
- Reset: on an edge with rst=0, every output and all pipeline registers go to 0, and valid_out=0 from the next cycle. Reset overrides refresh and valid_in.
- Pipeline: LAT = log2(NUM_STATES) register stages, one per compare-tree level. The final level is the output register.
  - A vector sampled at edge k appears on the outputs after edge k+LAT−1 and is readable in the following cycle. For NUM_STATES=4 it is visible after edge k+1.
  - Full throughput: one vector per cycle, with no backpressure and no stall.
- Compare node:
  - Takes (path, index, metric) pairs a (lower index) and b.
  - Passes b only if metric_b < metric_a, otherwise a. Ties therefore resolve to the lowest index.
  - Comparison is unsigned on METRIC_W bits, with no widening and no arithmetic.
- term_mode: sampled with the vector and carried down the pipeline.
  - When 1, the outputs are state 0's path, index 0 and state 0's metric, regardless of the other metrics.
  - norm_req is still computed on the emitted metric.
- write_pointer: carried unmodified through the pipeline, so wrap-around (e.g. 7→0) is transparent.
- valid pipeline:
  - Each stage carries a valid bit.
  - valid_in=0 inserts a bubble; data registers hold their previous value and valid_out=0 for that slot.
- refresh:
  - On an edge with refresh=1 (and rst=1), every stage valid bit is cleared. Any vector sampled at that same edge is discarded.
  - Data registers need not be cleared.
  - valid_out is 0 for the next LAT cycles unless new vectors enter after the refresh.
- norm_req: registered with the output stage. It equals (min_metric >= NORM_THRESH) when valid_out=1, and is forced to 0 when valid_out=0.
- Outputs change only on clk edges. There are no combinational input-to-output paths.

Test Plan:
1. Defaults. Paths {0xAA,0xCC,0xF0,0x0F}, metrics {1,2,3,4}, ptr 0, valid_in=1 for one edge → next cycle: valid_out=1, selected_path=0xAA, best_state=0, min_metric=1, write_pointer_out=0, norm_req=0. The cycle after that: valid_out=0.
2. Tie-break and minimum search.
   - Metrics all 5 with paths {0x00,0xFF,0xAA,0x55} → best_state=0, path 0x00.
   - Metrics {9,10,11,0} with paths {0xAA,0x55,0xCC,0x33} → best_state=3, path 0x33, min_metric=0.
3. Back-to-back and wrap. Three consecutive vectors with ptr 6,7,0 and metrics {4,3,2,1} → three consecutive valid_out cycles, ptr_out 6,7,0, best_state=3 each time.
4. term_mode and norm_req.
   - term_mode=1 with metrics {12,0,0,0}, paths {0x3C,…} → best_state=0, path 0x3C, min_metric=12, norm_req=1.
   - term_mode=0 with metrics {8,9,10,11} → norm_req=1.
   - term_mode=0 with metrics {7,9,9,9} → norm_req=0.
5. Refresh. Vector A at edge k, refresh=1 at edge k+1 alongside vector B, vector C at edge k+2 → A and B never produce valid_out; C is emitted with correct values one cycle after edge k+2.
6. Reset mid-flight. Two vectors in flight, rst=0 for one edge (with refresh=1 and valid_in=1) → from the next cycle all outputs are 0 and valid_out stays 0 until a new vector is sampled after rst returns to 1.
7. Parameter sweep. NUM_STATES=8, PATH_W=16, METRIC_W=6 → latency 3, minimum at index 5 selected, tie between indices 2 and 6 resolves to 2.

Source files
------------

// File: rtl/survivor_selector_n.sv
// survivor_selector_n: pipelined minimum-metric survivor selection over NUM_STATES paths.
module survivor_selector_n #(
    parameter int NUM_STATES  = 4,
    parameter int PATH_W      = 8,
    parameter int METRIC_W    = 4,
    parameter int PTR_W       = 3,
    parameter int NORM_THRESH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           refresh,
    input  logic                           valid_in,
    input  logic                           term_mode,
    input  logic [NUM_STATES*PATH_W-1:0]   paths_in,
    input  logic [NUM_STATES*METRIC_W-1:0] metrics_in,
    input  logic [PTR_W-1:0]               write_pointer_in,
    output logic [PATH_W-1:0]              selected_path,
    output logic [$clog2(NUM_STATES)-1:0]  best_state,
    output logic [METRIC_W-1:0]            min_metric,
    output logic [PTR_W-1:0]               write_pointer_out,
    output logic                           norm_req,
    output logic                           valid_out
);
    localparam int LAT = $clog2(NUM_STATES);
    genvar l;
    generate
        for (l = 0; l <= LAT; l++) begin : lv
            localparam int W = NUM_STATES >> l;
            logic [PATH_W-1:0]   p [W];
            logic [LAT-1:0]      x [W];
            logic [METRIC_W-1:0] m [W];
            logic [PTR_W-1:0]    ptr;
            logic                v;
            if (l == 0) begin : g_in
                // Terminated trellis: non-zero states get the maximum metric so they can never win a strict less-than.
                always_comb begin
                    for (int k = 0; k < W; k++) begin
                        p[k] = paths_in[k*PATH_W +: PATH_W];
                        x[k] = LAT'(k);
                        m[k] = (term_mode && k != 0) ? '1 : metrics_in[k*METRIC_W +: METRIC_W];
                    end
                end
                assign ptr = write_pointer_in;
                assign v   = valid_in;
            end else begin : g_st
                always_ff @(posedge clk) begin
                    if (!rst) begin
                        v   <= 1'b0;
                        ptr <= '0;
                        for (int k = 0; k < W; k++) begin
                            p[k] <= '0;
                            x[k] <= '0;
                            m[k] <= '0;
                        end
                    end else begin
                        v <= !refresh && lv[l-1].v;
                        if (lv[l-1].v) begin
                            ptr <= lv[l-1].ptr;
                            for (int k = 0; k < W; k++) begin
                                p[k] <= (lv[l-1].m[2*k+1] < lv[l-1].m[2*k]) ? lv[l-1].p[2*k+1] : lv[l-1].p[2*k];
                                x[k] <= (lv[l-1].m[2*k+1] < lv[l-1].m[2*k]) ? lv[l-1].x[2*k+1] : lv[l-1].x[2*k];
                                m[k] <= (lv[l-1].m[2*k+1] < lv[l-1].m[2*k]) ? lv[l-1].m[2*k+1] : lv[l-1].m[2*k];
                            end
                        end
                    end
                end
            end
        end
    endgenerate
    assign selected_path     = lv[LAT].p[0];
    assign best_state        = lv[LAT].x[0];
    assign min_metric        = lv[LAT].m[0];
    assign write_pointer_out = lv[LAT].ptr;
    assign valid_out         = lv[LAT].v;
    assign norm_req          = valid_out && (min_metric >= METRIC_W'(NORM_THRESH));
endmodule

// File: tb/tb_survivor_selector_n.sv
// tb_survivor_selector_n: scoreboard bench for a 4-state and an 8-state selector.
module tb_survivor_selector_n;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;
    int errs = 0, checks = 0;

    typedef struct {
        logic [15:0] path;
        logic [2:0]  st;
        logic [5:0]  met;
        logic [2:0]  ptr;
        logic        nrm;
        int          due;
    } exp_t;
    exp_t q0[$], q1[$];
    int rst_edge0 = 1, rst_edge1 = 1;

    logic r0 = 0, rf0 = 0, v0 = 0, t0 = 0;
    logic [31:0] pa0 = '0;
    logic [15:0] me0 = '0;
    logic [2:0]  w0 = '0, wo0;
    logic [7:0]  sp0;
    logic [1:0]  bs0;
    logic [3:0]  mm0;
    logic        nr0, vo0;

    logic r1 = 0, rf1 = 0, v1 = 0, t1 = 0;
    logic [127:0] pa1 = '0;
    logic [47:0]  me1 = '0;
    logic [2:0]   w1 = '0, wo1, bs1;
    logic [15:0]  sp1;
    logic [5:0]   mm1;
    logic         nr1, vo1;

    survivor_selector_n dut0 (
        .clk(clk), .rst(r0), .refresh(rf0), .valid_in(v0), .term_mode(t0),
        .paths_in(pa0), .metrics_in(me0), .write_pointer_in(w0),
        .selected_path(sp0), .best_state(bs0), .min_metric(mm0),
        .write_pointer_out(wo0), .norm_req(nr0), .valid_out(vo0)
    );

    survivor_selector_n #(.NUM_STATES(8), .PATH_W(16), .METRIC_W(6)) dut1 (
        .clk(clk), .rst(r1), .refresh(rf1), .valid_in(v1), .term_mode(t1),
        .paths_in(pa1), .metrics_in(me1), .write_pointer_in(w1),
        .selected_path(sp1), .best_state(bs1), .min_metric(mm1),
        .write_pointer_out(wo1), .norm_req(nr1), .valid_out(vo1)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cyc, got, want);
        end
    endtask

    // Winner is the first state holding the smallest metric; state 0 when terminated.
    function automatic exp_t model(input int n, input logic t, input logic [15:0] pa[8],
                                   input logic [5:0] me[8], input logic [2:0] w);
        exp_t e;
        int b = 0;
        if (!t)
            for (int k = 1; k < n; k++)
                if (me[k] < me[b]) b = k;
        e.path = pa[b];
        e.st   = 3'(b);
        e.met  = me[b];
        e.ptr  = w;
        e.nrm  = me[b] >= 8;
        e.due  = 0;
        return e;
    endfunction

    task automatic drive(input int d, input logic v, input logic t, input logic rf, input logic rs,
                         input logic [15:0] pa[8], input logic [5:0] me[8], input logic [2:0] w);
        exp_t e;
        @(posedge clk);
        #1;
        {v0, v1, rf0, rf1, t0, t1} = '0;
        r0 = 1'b1;
        r1 = 1'b1;
        if (d == 0) begin
            v0 = v; t0 = t; rf0 = rf; r0 = rs; w0 = w;
            for (int k = 0; k < 4; k++) begin
                pa0[k*8 +: 8] = pa[k][7:0];
                me0[k*4 +: 4] = me[k][3:0];
            end
            if (!rs || rf)
                while (q0.size() > 0 && q0[$].due >= cyc + 1) void'(q0.pop_back());
            if (!rs) rst_edge0 = cyc + 1;
            if (v && rs && !rf) begin
                e = model(4, t, pa, me, w);
                e.due = cyc + 2;
                q0.push_back(e);
            end
        end else begin
            v1 = v; t1 = t; rf1 = rf; r1 = rs; w1 = w;
            for (int k = 0; k < 8; k++) begin
                pa1[k*16 +: 16] = pa[k];
                me1[k*6 +: 6]   = me[k];
            end
            if (!rs || rf)
                while (q1.size() > 0 && q1[$].due >= cyc + 1) void'(q1.pop_back());
            if (!rs) rst_edge1 = cyc + 1;
            if (v && rs && !rf) begin
                e = model(8, t, pa, me, w);
                e.due = cyc + 3;
                q1.push_back(e);
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (cyc > 0) begin
            if (cyc == rst_edge0)
                chk("rst_zero4", {sp0, bs0, mm0, wo0, nr0, vo0}, 32'd0);
            if (q0.size() > 0 && q0[0].due == cyc) begin
                e = q0.pop_front();
                chk("valid4", 32'(vo0), 32'd1);
                chk("path4", 32'(sp0), 32'(e.path[7:0]));
                chk("state4", 32'(bs0), 32'(e.st[1:0]));
                chk("metric4", 32'(mm0), 32'(e.met[3:0]));
                chk("ptr4", 32'(wo0), 32'(e.ptr));
                chk("norm4", 32'(nr0), 32'(e.nrm));
            end else begin
                chk("idle_valid4", 32'(vo0), 32'd0);
                chk("idle_norm4", 32'(nr0), 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (cyc > 0) begin
            if (cyc == rst_edge1)
                chk("rst_zero8", {sp1, bs1, mm1, wo1, nr1, vo1}, 32'd0);
            if (q1.size() > 0 && q1[0].due == cyc) begin
                e = q1.pop_front();
                chk("valid8", 32'(vo1), 32'd1);
                chk("path8", 32'(sp1), 32'(e.path));
                chk("state8", 32'(bs1), 32'(e.st));
                chk("metric8", 32'(mm1), 32'(e.met));
                chk("ptr8", 32'(wo1), 32'(e.ptr));
                chk("norm8", 32'(nr1), 32'(e.nrm));
            end else begin
                chk("idle_valid8", 32'(vo1), 32'd0);
                chk("idle_norm8", 32'(nr1), 32'd0);
            end
        end
    end

    logic [15:0] P[8];
    logic [5:0]  M[8];

    task automatic idle(input int d, input int n);
        for (int i = 0; i < n; i++) drive(d, 0, 0, 0, 1, P, M, 3'd0);
    endtask

    task automatic rand_run(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            int top;
            top = ($urandom_range(0, 3) == 0) ? 3 : (d ? 63 : 15);
            for (int k = 0; k < 8; k++) begin
                P[k] = d ? 16'($urandom) : 16'($urandom_range(0, 255));
                M[k] = 6'($urandom_range(0, top));
            end
            drive(d, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 39) != 0, P, M, 3'($urandom));
        end
    endtask

    initial begin
        P = '{16'hAA, 16'hCC, 16'hF0, 16'h0F, 0, 0, 0, 0};
        M = '{1, 2, 3, 4, 0, 0, 0, 0};
        drive(0, 1, 0, 0, 1, P, M, 3'd0);
        idle(0, 2);
        P = '{16'h00, 16'hFF, 16'hAA, 16'h55, 0, 0, 0, 0};
        M = '{5, 5, 5, 5, 0, 0, 0, 0};
        drive(0, 1, 0, 0, 1, P, M, 3'd1);
        P = '{16'hAA, 16'h55, 16'hCC, 16'h33, 0, 0, 0, 0};
        M = '{9, 10, 11, 0, 0, 0, 0, 0};
        drive(0, 1, 0, 0, 1, P, M, 3'd2);
        M = '{4, 3, 2, 1, 0, 0, 0, 0};
        drive(0, 1, 0, 0, 1, P, M, 3'd6);
        drive(0, 1, 0, 0, 1, P, M, 3'd7);
        drive(0, 1, 0, 0, 1, P, M, 3'd0);
        P = '{16'h3C, 16'h11, 16'h22, 16'h33, 0, 0, 0, 0};
        M = '{12, 0, 0, 0, 0, 0, 0, 0};
        drive(0, 1, 1, 0, 1, P, M, 3'd3);
        M = '{8, 9, 10, 11, 0, 0, 0, 0};
        drive(0, 1, 0, 0, 1, P, M, 3'd4);
        M = '{7, 9, 9, 9, 0, 0, 0, 0};
        drive(0, 1, 0, 0, 1, P, M, 3'd5);
        idle(0, 2);
        M = '{3, 1, 2, 4, 0, 0, 0, 0};
        drive(0, 1, 0, 0, 1, P, M, 3'd1);
        drive(0, 1, 0, 1, 1, P, M, 3'd2);
        M = '{6, 7, 2, 9, 0, 0, 0, 0};
        drive(0, 1, 0, 0, 1, P, M, 3'd3);
        idle(0, 3);
        drive(0, 1, 0, 0, 1, P, M, 3'd4);
        drive(0, 1, 0, 0, 1, P, M, 3'd5);
        drive(0, 1, 0, 1, 0, P, M, 3'd6);
        idle(0, 3);
        drive(0, 1, 0, 0, 1, P, M, 3'd7);
        idle(0, 2);
        rand_run(0, 300);
        idle(0, 4);
        chk("drain4", 32'(q0.size()), 32'd0);

        P = '{16'h1000, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777};
        M = '{20, 30, 40, 35, 25, 3, 50, 60};
        drive(1, 1, 0, 0, 1, P, M, 3'd1);
        M = '{9, 9, 2, 9, 9, 9, 2, 9};
        drive(1, 1, 0, 0, 1, P, M, 3'd2);
        M = '{63, 1, 1, 1, 1, 1, 1, 1};
        drive(1, 1, 1, 0, 1, P, M, 3'd3);
        idle(1, 4);
        rand_run(1, 300);
        idle(1, 5);
        chk("drain8", 32'(q1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
